seg_timer_display: RTL and testbench

SEG_TIMER_DISPLAY -- requirements
Module: seg_timer_display

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 44 ++++
 rtl/seg_timer_display.sv | 124 ++++++++++++
 tb/tb_seg_timer_display.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared BCD and 7-segment definitions for the timer display.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Active-low patterns, bit order a..g (leftmost literal bit is segment a).
  localparam logic [0:6] SEG_TABLE [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: clamped load, up/down step, carry/borrow out.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_val,
  input  logic en,
  input  logic up,
  output bcd_t value_o,
  output bcd_t value_next_o,
  output logic cy_o
);

  bcd_t value_q, value_d;
  logic at_limit;

  // Next digit value: load wins, otherwise step with rollover at 9/0.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    value_d  = value_q;
    at_limit = up ? (value_q == BCD_MAX) : (value_q == '0);
    if (load) begin
      value_d = (load_val > BCD_MAX) ? BCD_MAX : load_val;
    end else if (en) begin
      if (at_limit) value_d = up ? bcd_t'(0) : BCD_MAX;
      else          value_d = up ? value_q + 4'd1 : value_q - 4'd1;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o      = value_q;
  assign value_next_o = value_d;
  // The next digit steps only when this one rolls over.
  assign cy_o         = en && at_limit && !load;

endmodule

// File: rtl/seg_timer_display.sv
// BCD up/down timer with prescaler and multiplexed 7-segment display.
module seg_timer_display
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  up,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done,
  output logic [0:6]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic                done_q, done_d;
  logic [0:6]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [4*DIGITS-1:0] cnt_q, cnt_d, term;
  logic [DIGITS:0]     en;
  logic                tick, step, at_term, wrap;

  // Digit chain: each digit steps when everything below it rolls over.
  assign en[0] = step;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_val     (load_val[4*i +: 4]),
      .en           (en[i]),
      .up           (up),
      .value_o      (cnt_q[4*i +: 4]),
      .value_next_o (cnt_d[4*i +: 4]),
      .cy_o         (en[i+1])
    );
  end
  // Carry out of the top digit means the count is wrapping between terminals.
  assign wrap = en[DIGITS];

  // Prescaler, step gating and terminal-value detection.
  always_comb begin
    tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    term    = up ? {DIGITS{BCD_MAX}} : '0;
    at_term = (cnt_q == term);
    step    = tick && run && !load && (wrap_en || !at_term);
    done_d  = step && !wrap && (cnt_d == term);
  end

  // Scan counter and registered segment/anode decode of the current digit.
  always_comb begin
    logic       zero_above;
    logic [DIGITS-1:0] blank;
    bcd_t       cur_digit;
    logic       cur_blank;
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
    // Blank a digit when it and every digit above it are zero; digit 0 always shows.
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (cnt_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above && (BLANK_LZ != 0);
    end
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_digit = cnt_q[4*i +: 4];
        cur_blank = blank[i];
      end
    end
    seg_d = (cur_blank || cur_digit > BCD_MAX) ? SEG_BLANK : SEG_TABLE[cur_digit];
    an_d  = ~(DIGITS'(1) << scan_idx_q);
  end

  // Prescaler, scan and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      done_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count = cnt_q;
  assign done  = done_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seg_timer_display.sv
// Directed scoreboard bench for seg_timer_display (tick every 10 cycles, digit period 5).
module tb_seg_timer_display;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset, run, up, wrap_en, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        done;
  logic [0:6]  seg;
  logic [3:0]  an;

  seg_timer_display #(
    .DIGITS(DIGITS), .CLK_HZ(1000), .TICK_HZ(100), .REFRESH_HZ(50), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .up(up), .wrap_en(wrap_en),
    .load(load), .load_val(load_val), .count(count), .done(done),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; count updates on multiples of 10.
  int edge_n = 0;
  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [0:6] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: ref_seg = 7'b0000001;
      4'd1: ref_seg = 7'b1001111;
      4'd2: ref_seg = 7'b0010010;
      4'd3: ref_seg = 7'b0000110;
      4'd4: ref_seg = 7'b1001100;
      4'd5: ref_seg = 7'b0100100;
      4'd6: ref_seg = 7'b0100000;
      4'd7: ref_seg = 7'b0001111;
      4'd8: ref_seg = 7'b0000000;
      4'd9: ref_seg = 7'b0000100;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic expect_cnt_done(input string tag, input logic [15:0] c, input logic d);
    push({tag, "_count"}, {16'h0, c});
    push({tag, "_done"}, {31'h0, d});
    sb_check({16'h0, count});
    sb_check({31'h0, done});
  endtask

  // Advance to the negedge following the next tick edge.
  task automatic to_tick_edge();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edge_n % 10 != 0 || edge_n == 0) && n < 25);
    if (n >= 25) begin
      total++;
      $error("FAIL tick_wait: no tick edge within %0d cycles, required within 10", n);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [15:0] expv, input string tag);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    push(tag, {16'h0, expv});
    @(negedge clk);
    load = 1'b0;
    sb_check({16'h0, count});
  endtask

  // One full refresh period: an/seg reflect scan index and count of the previous cycle.
  task automatic check_display(input logic [15:0] cv);
    int       k, idx;
    logic     blank;
    logic [15:0] shifted;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      k       = edge_n;
      idx     = ((k - 1) / 5) % 4;
      shifted = cv >> (4 * idx);
      blank   = (idx != 0) && (shifted == 16'h0);
      push($sformatf("an_e%0d", k), {28'h0, ~(4'b0001 << idx)});
      push($sformatf("seg_e%0d", k), {25'h0, blank ? 7'b1111111 : ref_seg(shifted[3:0])});
      sb_check({28'h0, an});
      sb_check({25'h0, seg});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; up = 1'b0; wrap_en = 1'b0; load = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    expect_cnt_done("rst", 16'h0000, 1'b0);
    push("rst_seg", 32'h7F); sb_check({25'h0, seg});
    push("rst_an", 32'hF);   sb_check({28'h0, an});

    // First post-reset update: digit 0 selected, showing "0".
    reset = 1'b0;
    @(negedge clk);
    push("first_an", 32'hE);  sb_check({28'h0, an});
    push("first_seg", {25'h0, ref_seg(4'd0)}); sb_check({25'h0, seg});

    // Count down 0003 to 0000 and saturate.
    do_load(16'h0003, 16'h0003, "load_0003");
    run = 1'b1;
    to_tick_edge(); expect_cnt_done("dn_2", 16'h0002, 1'b0);
    to_tick_edge(); expect_cnt_done("dn_1", 16'h0001, 1'b0);
    to_tick_edge(); expect_cnt_done("dn_0", 16'h0000, 1'b1);
    @(negedge clk); expect_cnt_done("dn_0_after", 16'h0000, 1'b0);
    to_tick_edge(); expect_cnt_done("sat_0a", 16'h0000, 1'b0);
    to_tick_edge(); expect_cnt_done("sat_0b", 16'h0000, 1'b0);

    // Count up 9998 with wrap.
    run = 1'b0; up = 1'b1; wrap_en = 1'b1;
    do_load(16'h9998, 16'h9998, "load_9998");
    run = 1'b1;
    to_tick_edge(); expect_cnt_done("up_9999", 16'h9999, 1'b1);
    @(negedge clk); expect_cnt_done("up_9999_after", 16'h9999, 1'b0);
    to_tick_edge(); expect_cnt_done("wrap_0000", 16'h0000, 1'b0);

    // Saturate at 9999, then reverse direction.
    run = 1'b0; wrap_en = 1'b0;
    do_load(16'h9998, 16'h9998, "load_9998_sat");
    run = 1'b1;
    to_tick_edge(); expect_cnt_done("sat_9999", 16'h9999, 1'b1);
    to_tick_edge(); expect_cnt_done("sat_hold", 16'h9999, 1'b0);
    up = 1'b0;
    to_tick_edge(); expect_cnt_done("rev_9998", 16'h9998, 1'b0);

    // Carry across two digits and load clamping.
    run = 1'b0; up = 1'b1;
    do_load(16'h0199, 16'h0199, "load_0199");
    run = 1'b1;
    to_tick_edge(); expect_cnt_done("carry_0200", 16'h0200, 1'b0);
    run = 1'b0;
    do_load(16'h00F5, 16'h0095, "clamp_00F5");
    do_load(16'hFA3C, 16'h9939, "clamp_FA3C");

    // Load on a tick cycle wins over the step.
    do_load(16'h0050, 16'h0050, "load_0050");
    for (int n = 0; n < 12 && (edge_n % 10 != 9); n++) @(negedge clk);
    load = 1'b1; load_val = 16'h0007; run = 1'b1;
    @(negedge clk);
    load = 1'b0; run = 1'b0;
    expect_cnt_done("tick_load", 16'h0007, 1'b0);
    @(negedge clk);
    expect_cnt_done("tick_load_after", 16'h0007, 1'b0);

    // Display scan with leading-zero blanking.
    do_load(16'h0042, 16'h0042, "load_0042");
    check_display(16'h0042);
    do_load(16'h0105, 16'h0105, "load_0105");
    check_display(16'h0105);

    // Reset mid-count overrides a same-cycle load.
    up = 1'b1; wrap_en = 1'b0;
    do_load(16'h0123, 16'h0123, "load_0123");
    run = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; load = 1'b1; load_val = 16'h0777;
    @(negedge clk);
    expect_cnt_done("mid_rst", 16'h0000, 1'b0);
    push("mid_rst_seg", 32'h7F); sb_check({25'h0, seg});
    push("mid_rst_an", 32'hF);   sb_check({28'h0, an});
    load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      push($sformatf("post_rst_e%0d", k), (k < 10) ? 32'h0000 : 32'h0001);
      sb_check({16'h0, count});
    end

    if (sb_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover: observed %0d pending, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
